// File: rtl/Modules_pkg.sv
// Shared types and constants for the RV32F post-processing stages.
// Holds FSM states, rounding modes, IEEE-754 field layout and fflags bit positions.
package Modules_pkg;

  localparam int XLEN     = 32;
  localparam int QUOT_MSB = 26;

  localparam logic [31:0]       CANONICAL_NAN = 32'h7FC00000;
  localparam logic signed [9:0] EXP_MAX       = 10'sd255;

  // fflags order is {NV, DZ, OF, UF, NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORMALIZE,
    ST_ROUND,
    ST_VALID
  } fsm_state_e;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rv_rm_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp_fields_s;

  function automatic logic [31:0] pack_fp(input logic s, input logic [7:0] e, input logic [22:0] m);
    fp_fields_s f;
    f.sign = s;
    f.exp  = e;
    f.mant = m;
    return f;
  endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Rounding increment and overflow-direction decision for RISC-V rounding modes.
// Purely combinational so the FMUL/FADD post stages can share it.
module fp_round_decide
  import Modules_pkg::*;
(
  input  logic [2:0] rm_i,
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       guard_i,
  input  logic       round_i,
  input  logic       sticky_i,
  output logic       inc_o,
  output logic       ovf_inf_o
);

  logic w_any;

  assign w_any = guard_i | round_i | sticky_i;

  // Reserved encodings 5-7 fall through to round-to-nearest-even.
  always_comb begin
    inc_o     = guard_i & (round_i | sticky_i | lsb_i);
    ovf_inf_o = 1'b1;
    case (rm_i)
      RM_RTZ: begin
        inc_o     = 1'b0;
        ovf_inf_o = 1'b0;
      end
      RM_RDN: begin
        inc_o     = sign_i & w_any;
        ovf_inf_o = sign_i;
      end
      RM_RUP: begin
        inc_o     = ~sign_i & w_any;
        ovf_inf_o = ~sign_i;
      end
      RM_RMM: begin
        inc_o     = guard_i;
        ovf_inf_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_div_post_normalizer.sv
// FDIV.S back end: normalizes the divider quotient, rounds, resolves specials
// and packs a single-precision result with fflags, one operation at a time.
module fp_div_post_normalizer
  import Modules_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clk_en_i,
  input  logic                   valid_i,
  input  logic [XLEN-1:0]        quotient_i,
  input  logic                   rem_nz_i,
  input  logic                   sign_i,
  input  logic signed [9:0]      exp_i,
  input  logic [2:0]             rm_i,
  input  logic                   nan_i,
  input  logic                   inv_i,
  input  logic                   a_inf_i,
  input  logic                   a_zero_i,
  input  logic                   b_inf_i,
  input  logic                   b_zero_i,
  output logic [31:0]            result_o,
  output logic                   valid_o,
  output logic [4:0]             flags_o
);

  fsm_state_e r_state;

  logic [QUOT_MSB:0] r_quot;
  logic              r_rem_nz;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [2:0]        r_rm;
  logic              r_nan;
  logic              r_inv;
  logic              r_a_inf;
  logic              r_a_zero;
  logic              r_b_inf;
  logic              r_b_zero;

  logic [22:0]       r_mant;
  logic              r_g;
  logic              r_r;
  logic              r_s;
  logic signed [9:0] r_e;

  logic [31:0]       r_result;
  logic [4:0]        r_flags;
  logic              r_valid;

  logic [22:0]       w_norm_mant;
  logic              w_norm_g;
  logic              w_norm_r;
  logic              w_norm_s;
  logic signed [9:0] w_norm_e;

  logic              w_inc;
  logic              w_ovf_inf;
  logic [23:0]       w_sum;
  logic signed [9:0] w_e_rnd;
  logic              w_inexact;
  logic [31:0]       w_result;
  logic [4:0]        w_flags;
  logic              w_unused_hi;

  // The divider guarantees the upper quotient bits are zero.
  assign w_unused_hi = |quotient_i[XLEN-1:QUOT_MSB+1];

  // A quotient below 1.0 has its leading one one place lower and needs e-1.
  assign w_norm_mant = r_quot[QUOT_MSB] ? r_quot[25:3] : r_quot[24:2];
  assign w_norm_g    = r_quot[QUOT_MSB] ? r_quot[2]    : r_quot[1];
  assign w_norm_r    = r_quot[QUOT_MSB] ? r_quot[1]    : r_quot[0];
  assign w_norm_s    = r_quot[QUOT_MSB] ? (r_quot[0] | r_rem_nz) : r_rem_nz;
  assign w_norm_e    = r_quot[QUOT_MSB] ? r_exp : (r_exp - 10'sd1);

  fp_round_decide u_round_decide (
    .rm_i      (r_rm),
    .sign_i    (r_sign),
    .lsb_i     (r_mant[0]),
    .guard_i   (r_g),
    .round_i   (r_r),
    .sticky_i  (r_s),
    .inc_o     (w_inc),
    .ovf_inf_o (w_ovf_inf)
  );

  // Carry out of the 24-bit significand leaves the fraction at zero and bumps e.
  assign w_sum     = {1'b0, r_mant} + {23'd0, w_inc};
  assign w_e_rnd   = r_e + $signed({9'd0, w_sum[23]});
  assign w_inexact = r_g | r_r | r_s;

  always_comb begin
    w_result          = pack_fp(r_sign, w_e_rnd[7:0], w_sum[22:0]);
    w_flags           = 5'd0;
    w_flags[FLAG_NX]  = w_inexact;
    if (r_nan | r_inv) begin
      w_result         = CANONICAL_NAN;
      w_flags          = 5'd0;
      w_flags[FLAG_NV] = r_inv;
    end else if (r_b_zero) begin
      w_result         = pack_fp(r_sign, 8'hFF, 23'd0);
      w_flags          = 5'd0;
      w_flags[FLAG_DZ] = 1'b1;
    end else if (r_a_inf) begin
      w_result = pack_fp(r_sign, 8'hFF, 23'd0);
      w_flags  = 5'd0;
    end else if (r_a_zero | r_b_inf) begin
      w_result = pack_fp(r_sign, 8'h00, 23'd0);
      w_flags  = 5'd0;
    end else if (w_e_rnd >= EXP_MAX) begin
      w_result         = w_ovf_inf ? pack_fp(r_sign, 8'hFF, 23'd0)
                                   : pack_fp(r_sign, 8'hFE, 23'h7FFFFF);
      w_flags          = 5'd0;
      w_flags[FLAG_OF] = 1'b1;
      w_flags[FLAG_NX] = 1'b1;
    end else if (w_e_rnd <= 10'sd0) begin
      w_result         = pack_fp(r_sign, 8'h00, 23'd0);
      w_flags          = 5'd0;
      w_flags[FLAG_UF] = 1'b1;
      w_flags[FLAG_NX] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_quot   <= '0;
      r_rem_nz <= 1'b0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_rm     <= '0;
      r_nan    <= 1'b0;
      r_inv    <= 1'b0;
      r_a_inf  <= 1'b0;
      r_a_zero <= 1'b0;
      r_b_inf  <= 1'b0;
      r_b_zero <= 1'b0;
      r_mant   <= '0;
      r_g      <= 1'b0;
      r_r      <= 1'b0;
      r_s      <= 1'b0;
      r_e      <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_valid  <= 1'b0;
    end else if (clk_en_i) begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            r_quot   <= quotient_i[QUOT_MSB:0];
            r_rem_nz <= rem_nz_i;
            r_sign   <= sign_i;
            r_exp    <= exp_i;
            r_rm     <= rm_i;
            r_nan    <= nan_i;
            r_inv    <= inv_i;
            r_a_inf  <= a_inf_i;
            r_a_zero <= a_zero_i;
            r_b_inf  <= b_inf_i;
            r_b_zero <= b_zero_i;
            r_state  <= ST_NORMALIZE;
          end
        end
        ST_NORMALIZE: begin
          r_mant  <= w_norm_mant;
          r_g     <= w_norm_g;
          r_r     <= w_norm_r;
          r_s     <= w_norm_s;
          r_e     <= w_norm_e;
          r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_result <= w_result;
          r_flags  <= w_flags;
          r_valid  <= 1'b1;
          r_state  <= ST_VALID;
        end
        ST_VALID: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign result_o = r_result;
  assign flags_o  = r_flags;
  assign valid_o  = r_valid;

endmodule
